// File: rtl/rr_arb_pkg.sv
// ---------------------------------------------------------------------------
// rr_arb_pkg
// Shared definitions for the round-robin byte arbiter:
//   NREQ        - number of requesters (fixed at 16)
//   SEL_W       - width of the lane select / pointer
//   out_state_t - occupancy of the registered output slot
//   lane_lsb()  - bit offset of a lane inside the packed lane data bus
// ---------------------------------------------------------------------------
package rr_arb_pkg;

    localparam int unsigned NREQ  = 16;
    localparam int unsigned SEL_W = 4;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

    // Lane i occupies [(i+1)*width-1 : i*width] of the packed input bus.
    function automatic int unsigned lane_lsb(input logic [SEL_W-1:0] lane,
                                             input int unsigned      width);
        return 32'(lane) * width;
    endfunction

endpackage

// File: rtl/rr_pick16.sv
// ---------------------------------------------------------------------------
// rr_pick16
// Combinational rotate-priority finder. Scans req starting at ptr and
// wrapping modulo 16; returns the first requesting lane.
// Ports:
//   req     in  16  per-lane request
//   ptr     in  4   highest-priority lane this cycle
//   winner  out 4   first requesting lane at or after ptr (0 when none)
//   any_req out 1   at least one lane is requesting
// ---------------------------------------------------------------------------
module rr_pick16
    import rr_arb_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] winner,
    output logic             any_req
);

    logic [SEL_W-1:0] idx;

    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        idx     = '0;
        // The 4-bit add wraps naturally, giving ptr, ptr+1, ..., ptr-1.
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = ptr + SEL_W'(k);
            if (!any_req && req[idx]) begin
                winner  = idx;
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_byte_arbiter.sv
// ---------------------------------------------------------------------------
// rr_byte_arbiter
// Round-robin arbiter sharing one 16:1 byte selector among 16 requesters.
// The winning byte is captured into a registered valid/ready output slot and
// the winner receives a one-cycle one-hot acknowledge.
//
// Ports:
//   clk        in   1         system clock, rising edge
//   rst_n      in   1         asynchronous active-low reset
//   req        in   16        per-lane request (level, held until acked)
//   in_data    in   16*WIDTH  packed lane data, lane i at [(i+1)*WIDTH-1:i*WIDTH]
//   lock       in   16        burst lock per lane (only with RR_BYTE_ARBITER_LOCK_EN)
//   ack        out  16        one-hot pulse: lane's byte captured this edge
//   out_valid  out  1         out_data/out_src hold a captured byte
//   out_ready  in   1         consumer accepts when out_valid & out_ready
//   out_data   out  WIDTH     captured byte
//   out_src    out  4         lane that supplied out_data
//
// Build option:
//   RR_BYTE_ARBITER_LOCK_EN - when defined, the lane granted at the last
//   capture keeps winning (without advancing the pointer) while its lock and
//   req are both high, allowing multi-byte bursts.
// ---------------------------------------------------------------------------
module rr_byte_arbiter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREQ  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] in_data,
`ifdef RR_BYTE_ARBITER_LOCK_EN
    input  logic [NREQ-1:0]       lock,
`endif
    output logic [NREQ-1:0]       ack,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [3:0]            out_src
);

    import rr_arb_pkg::*;

    out_state_t       state;
    out_state_t       state_nxt;

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] ptr_nxt;
    logic [SEL_W-1:0] rr_winner;
    logic [SEL_W-1:0] winner;
    logic             any_req;
    logic             load;
    logic             capture;
    logic [WIDTH-1:0] sel_byte;

    rr_pick16 u_pick (
        .req     (req),
        .ptr     (ptr),
        .winner  (rr_winner),
        .any_req (any_req)
    );

`ifdef RR_BYTE_ARBITER_LOCK_EN
    // out_src always names the lane granted at the last capture, so it
    // doubles as the locked lane; lock_vld only guards the post-reset case.
    logic lock_vld;
    logic lock_hit;

    assign lock_hit = lock_vld & lock[out_src] & req[out_src];
    assign winner   = lock_hit ? out_src : rr_winner;
    assign ptr_nxt  = lock_hit ? ptr : rr_winner + SEL_W'(1);
`else
    assign winner   = rr_winner;
    assign ptr_nxt  = rr_winner + SEL_W'(1);
`endif

    // Slot is empty or drains this cycle, so it can take a new byte.
    assign load     = ~out_valid | out_ready;
    assign capture  = load & any_req;
    assign sel_byte = in_data[lane_lsb(winner, WIDTH) +: WIDTH];

    assign out_valid = (state == FULL);

    // Output-slot occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: begin
                if (any_req) begin
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (out_ready) begin
                    state_nxt = any_req ? FULL : EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Datapath, pointer and acknowledge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            out_src  <= '0;
            ack      <= '0;
            ptr      <= '0;
`ifdef RR_BYTE_ARBITER_LOCK_EN
            lock_vld <= 1'b0;
`endif
        end else begin
            ack <= '0;
            if (capture) begin
                out_data <= sel_byte;
                out_src  <= winner;
                ack      <= {{(NREQ-1){1'b0}}, 1'b1} << winner;
                ptr      <= ptr_nxt;
`ifdef RR_BYTE_ARBITER_LOCK_EN
                lock_vld <= 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_rr_byte_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_byte_arbiter
// Self-checking bench for rr_byte_arbiter: a table of single-cycle vectors
// with hand-computed results, followed by directed multi-cycle sequences
// (async reset, full rotation, wrap, backpressure, single requester and,
// when RR_BYTE_ARBITER_LOCK_EN is defined, burst lock).
// ---------------------------------------------------------------------------
module tb_rr_byte_arbiter;

    localparam int unsigned WIDTH = 8;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [15:0]         req;
    logic [16*WIDTH-1:0] in_data;
    logic [15:0]         ack;
    logic                out_valid;
    logic                out_ready;
    logic [WIDTH-1:0]    out_data;
    logic [3:0]          out_src;
`ifdef RR_BYTE_ARBITER_LOCK_EN
    logic [15:0]         lock;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rr_byte_arbiter #(
        .WIDTH (WIDTH),
        .NREQ  (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .in_data   (in_data),
`ifdef RR_BYTE_ARBITER_LOCK_EN
        .lock      (lock),
`endif
        .ack       (ack),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src)
    );

    typedef struct {
        logic [15:0] req;
        logic        rdy;
        logic        ev;
        logic [3:0]  esrc;
        logic [7:0]  edata;
        logic [15:0] eack;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic ev, input logic [3:0] es,
                           input logic [7:0] ed, input logic [15:0] ea);
        chk({tag, ".valid"}, 32'(out_valid), 32'(ev));
        chk({tag, ".src"},   32'(out_src),   32'(es));
        chk({tag, ".data"},  32'(out_data),  32'(ed));
        chk({tag, ".ack"},   32'(ack),       32'(ea));
    endtask

    // Advance one clock and sample 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic default_data();
        for (int i = 0; i < 16; i++) begin
            in_data[i*WIDTH +: WIDTH] = 8'h10 + 8'(i);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req       = '0;
        out_ready = 1'b0;
`ifdef RR_BYTE_ARBITER_LOCK_EN
        lock      = '0;
`endif
        default_data();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //            req       rdy   v     src    data   ack
        tbl[0]  = '{16'h0000, 1'b0, 1'b0, 4'd0,  8'h00, 16'h0000};
        tbl[1]  = '{16'h0010, 1'b0, 1'b1, 4'd4,  8'h14, 16'h0010};
        tbl[2]  = '{16'h0001, 1'b0, 1'b1, 4'd4,  8'h14, 16'h0000};
        tbl[3]  = '{16'h0001, 1'b1, 1'b1, 4'd0,  8'h10, 16'h0001};
        tbl[4]  = '{16'h0101, 1'b1, 1'b1, 4'd8,  8'h18, 16'h0100};
        tbl[5]  = '{16'h0101, 1'b1, 1'b1, 4'd0,  8'h10, 16'h0001};
        tbl[6]  = '{16'h0000, 1'b1, 1'b0, 4'd0,  8'h10, 16'h0000};
        tbl[7]  = '{16'h0000, 1'b0, 1'b0, 4'd0,  8'h10, 16'h0000};
        tbl[8]  = '{16'h8002, 1'b0, 1'b1, 4'd1,  8'h11, 16'h0002};
        tbl[9]  = '{16'h8002, 1'b1, 1'b1, 4'd15, 8'h1F, 16'h8000};
        tbl[10] = '{16'h8002, 1'b1, 1'b1, 4'd1,  8'h11, 16'h0002};
        tbl[11] = '{16'h0000, 1'b1, 1'b0, 4'd1,  8'h11, 16'h0000};

        // Reset state
        do_reset();
        chk_out("reset", 1'b0, 4'd0, 8'h00, 16'h0000);

        // Table vectors, starting from ptr=0 and an empty slot
        for (int i = 0; i < 12; i++) begin
            req       = tbl[i].req;
            out_ready = tbl[i].rdy;
            tick();
            chk_out($sformatf("tbl%0d", i), tbl[i].ev, tbl[i].esrc, tbl[i].edata, tbl[i].eack);
        end

        // Asynchronous reset while a byte is held
        req       = 16'h0040;
        out_ready = 1'b0;
        tick();
        chk_out("prerst", 1'b1, 4'd6, 8'h16, 16'h0040);
        #3;
        rst_n = 1'b0;
        #1;
        chk_out("asyncrst", 1'b0, 4'd0, 8'h00, 16'h0000);
        tick();
        rst_n     = 1'b1;
        req       = 16'h0081;
        out_ready = 1'b1;
        tick();
        chk_out("rst_ptr0", 1'b1, 4'd0, 8'h10, 16'h0001);

        // All lanes requesting: strict rotation with no gaps
        do_reset();
        req       = 16'hFFFF;
        out_ready = 1'b1;
        for (int k = 0; k < 17; k++) begin
            tick();
            chk_out($sformatf("all16_%0d", k), 1'b1, 4'(k % 16),
                    8'h10 + 8'(k % 16), 16'(1) << (k % 16));
        end

        // Lanes 0 and 15: wrap from 15 back to 0
        do_reset();
        req       = 16'h8001;
        out_ready = 1'b1;
        tick();
        chk_out("wrap0", 1'b1, 4'd0, 8'h10, 16'h0001);
        tick();
        chk_out("wrap1", 1'b1, 4'd15, 8'h1F, 16'h8000);
        tick();
        chk_out("wrap2", 1'b1, 4'd0, 8'h10, 16'h0001);

        // Backpressure: lane 3 held for 4 stalled cycles, lane 7 waiting
        do_reset();
        in_data[3*WIDTH +: WIDTH] = 8'hA5;
        req       = 16'h0008;
        out_ready = 1'b0;
        tick();
        chk_out("bp_cap", 1'b1, 4'd3, 8'hA5, 16'h0008);
        req = 16'h0080;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_out($sformatf("bp_stall%0d", k), 1'b1, 4'd3, 8'hA5, 16'h0000);
        end
        out_ready = 1'b1;
        tick();
        chk_out("bp_drain", 1'b1, 4'd7, 8'h17, 16'h0080);
        default_data();

        // Single requester is granted every cycle
        do_reset();
        req       = 16'h0200;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_out($sformatf("single%0d", k), 1'b1, 4'd9, 8'h19, 16'h0200);
        end

`ifdef RR_BYTE_ARBITER_LOCK_EN
        // Burst lock on lane 2 with lane 5 competing
        do_reset();
        req       = 16'h0024;
        lock      = 16'h0004;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_out($sformatf("lock%0d", k), 1'b1, 4'd2, 8'h12, 16'h0004);
        end
        lock = 16'h0000;
        tick();
        chk_out("lock_rel", 1'b1, 4'd5, 8'h15, 16'h0020);
        tick();
        chk_out("lock_rr", 1'b1, 4'd2, 8'h12, 16'h0004);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_byte_arbiter.md
Name: rr_byte_arbiter

Overview:
- Round-robin arbiter that shares one 16-way byte selector among 16 requesters and forwards the winning byte through a registered valid/ready output stage.
- Sits between per-lane byte producers and a single byte consumer in the multi-cycle CPU datapath, for example bus or memory write-back.
- Generates the 4-bit select for the byte selector and a one-hot acknowledge back to the requesters.

Parameters:
- WIDTH, 8, byte lane width; the 16*WIDTH input bus is packed with lane i at [(i+1)*WIDTH-1 : i*WIDTH].
- NREQ, 16, requester count; fixed, no other value supported.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  16  per-lane request; level, held until acked.
- in_data  input  16*WIDTH  packed lane data; lane i valid while req[i]=1.
- ack  output  16  one-hot, one-cycle pulse; lane i's byte was captured this edge.
- out_valid  output  1  out_data/out_src hold a captured byte.
- out_ready  input  1  consumer accepts when out_valid & out_ready.
- out_data  output  WIDTH  captured byte.
- out_src  output  4  index of the lane that supplied out_data.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low on rst_n.
- Reset values: out_valid=0, out_data=0, out_src=0, ack=0, priority pointer ptr=0, lock state cleared.
- Load condition: load = ~out_valid | out_ready, meaning the output slot is empty or drains this cycle.
- Arbitration is combinational: winner = first i with req[i]=1, scanning ptr, ptr+1, …, 15, 0, …, ptr-1 (mod 16).
- The winner index drives the internal 16:1 byte select (sel=winner).
- Capture: if load and |req, then at the clock edge:
  - out_data <= selected byte, out_src <= winner, out_valid <= 1;
  - ack <= one-hot(winner) for exactly one cycle;
  - ptr <= winner+1 mod 16 (15 wraps to 0).
- If load and no req: out_valid <= 0, ack <= 0, ptr unchanged.
- If ~load (stall: out_valid & ~out_ready): all registers hold, ack <= 0, no new grant.
- Latency: req[i] sampled at edge n → out_valid=1 and ack[i]=1 after edge n.
- Throughput: one byte per cycle while out_ready=1 and requests are pending.
- Requester rule: on seeing ack[i]=1, the requester drops or advances req[i]/data before the next edge. The arbiter never grants the same lane on two consecutive edges while another lane is requesting, because ptr advanced past it.
- Single requester: continuously granted every cycle (ptr wraps back to it).
- Simultaneous drain and new request: output is replaced in the same edge, with no bubble.
- req deasserted while not yet granted: simply no longer considered; no error.
- Reset mid-transfer: any captured, unaccepted byte is discarded; out_valid=0 immediately (async).
- States:
  - EMPTY (out_valid=0): → FULL on any req.
  - FULL (out_valid=1): stays FULL on stall; on accept, → FULL if req pending, else → EMPTY.

Optional Feature:
- Macro: RR_BYTE_ARBITER_LOCK_EN.
- When defined:
  - Adds input lock[15:0].
  - If the lane granted at the last capture has lock=1 and req=1, it wins the next capture regardless of ptr, and ptr is not advanced. This allows multi-byte bursts.
  - Lock ends when that lane's lock or req drops; normal round-robin then resumes from the stored ptr.
  - Reset clears the lock state.
- When undefined: no lock port; pure round-robin.

Decomposition:
- Shared package rr_arb_pkg: NREQ=16, SEL_W=4, lane-slice helper function (lane index → packed bit offset), out-state enum {EMPTY, FULL}.
- One natural sub-module: rr_pick16, a combinational rotate-priority finder. It takes req[15:0] and ptr[3:0] and returns winner[3:0] and any_req.
- Byte selection is an inline indexed part-select.

Test Plan:
- Reset then idle: rst_n=0 mid-run with out_valid=1 → out_valid/ack/out_src drop to 0 immediately; after release, ptr=0.
- All 16 req high, lane i data=8'h10+i, out_ready=1 → out_src sequence 0,1,…,15,0; out_data 8'h10..8'h1F; one ack per cycle, no gaps.
- req=16'h8001, ptr=0 (held by stall) → lane 0 granted, then 15, then 0; the 15→0 wrap is checked.
- Backpressure: capture lane 3 (8'hA5), out_ready=0 for 4 cycles with req[7] high → out_data stays 8'hA5, no ack; on out_ready=1 lane 7 is captured the same edge.
- Single requester lane 9 held high, out_ready=1 → granted every cycle, out_src=9 continuously.
- LOCK_EN build: lanes 2 and 5 request, lock[2]=1 for 3 grants → out_src 2,2,2, then 5; ptr resumes at 3.
